// File: rtl/mult_pkg.sv
// Shared widths and the result record for the multiplier and its downstream consumers.
package mult_pkg;

  localparam int unsigned PROD_W    = 128;
  localparam int unsigned GUARD_W   = 8;
  localparam int unsigned ACC_W     = PROD_W + GUARD_W;
  localparam int unsigned TERM_W    = 16;
  localparam int unsigned OUT_DEPTH = 2;

  typedef struct packed {
    logic [ACC_W-1:0]  data;
    logic [TERM_W-1:0] terms;
    logic              ovf;
  } result_t;

endpackage

// File: rtl/mult_product_accumulator_if.sv
// Product-stream input and group-result output of the product accumulator.
interface mult_product_accumulator_if;
  import mult_pkg::*;

  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_last;
  logic [ACC_W-1:0]  res_data;
  logic [TERM_W-1:0] res_terms;
  logic              res_ovf;
  logic              res_valid;
  logic              res_ready;
  logic              drop_pulse;
  logic              busy;

  // Upstream multiplier plus result consumer
  modport master (
    output prod_in, prod_valid, prod_last, res_ready,
    input  res_data, res_terms, res_ovf, res_valid, drop_pulse, busy
  );

  // Accumulator side
  modport slave (
    input  prod_in, prod_valid, prod_last, res_ready,
    output res_data, res_terms, res_ovf, res_valid, drop_pulse, busy
  );
endinterface

// File: rtl/mult_result_fifo.sv
// Synchronous valid/ready FIFO; a push into a full buffer with no pop is dropped and flagged.
module mult_result_fifo
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = result_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic ready,
  output T     head,
  output logic head_valid,
  output logic drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           valid_q;
  logic           drop_q;

  logic           pop_c;
  logic           full_c;
  logic           push_ok_c;
  logic [CW-1:0]  count_nxt_c;

  // A pop in the same cycle frees the slot the push needs
  always_comb begin
    pop_c       = valid_q & ready;
    full_c      = (count == CW'(DEPTH));
    push_ok_c   = push & (~full_c | pop_c);
    count_nxt_c = count + CW'(push_ok_c) - CW'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (push_ok_c) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt_c;
      valid_q <= (count_nxt_c != '0);
      drop_q  <= push & full_c & ~pop_c;
    end
  end

  assign head       = mem[rd_ptr];
  assign head_valid = valid_q;
  assign drop       = drop_q;

endmodule

// File: rtl/mult_product_accumulator.sv
// Sums 128-bit products over last-terminated groups and buffers finished group results.
module mult_product_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned OUT_DEPTH_P = OUT_DEPTH
) (
  input logic                       clk,
  input logic                       rst,
  mult_product_accumulator_if.slave bus
);

  logic [ACC_W-1:0]  acc;
  logic [TERM_W-1:0] terms;
  logic              ovf_acc;
  logic              busy_q;

  logic [ACC_W-1:0]  base_acc_c;
  logic [TERM_W-1:0] base_terms_c;
  logic              base_ovf_c;
  logic [ACC_W:0]    sum_c;
  result_t           res_c;
  logic              push_c;
  result_t           head;
  logic              head_valid;
  logic              drop;

  // A beat arriving while idle starts a fresh group from zero
  always_comb begin
    base_acc_c   = busy_q ? acc     : '0;
    base_terms_c = busy_q ? terms   : '0;
    base_ovf_c   = busy_q ? ovf_acc : 1'b0;
    sum_c        = {1'b0, base_acc_c} + (ACC_W + 1)'(bus.prod_in);
    res_c.data   = sum_c[ACC_W-1:0];
    res_c.terms  = (base_terms_c == '1) ? base_terms_c : base_terms_c + TERM_W'(1);
    res_c.ovf    = base_ovf_c | sum_c[ACC_W];
    push_c       = bus.prod_valid & bus.prod_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      terms   <= '0;
      ovf_acc <= 1'b0;
      busy_q  <= 1'b0;
    end else if (bus.prod_valid) begin
      acc     <= res_c.data;
      terms   <= res_c.terms;
      ovf_acc <= res_c.ovf;
      busy_q  <= ~bus.prod_last;
    end
  end

  mult_result_fifo #(
    .DEPTH (OUT_DEPTH_P),
    .T     (result_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_c),
    .push_data  (res_c),
    .ready      (bus.res_ready),
    .head       (head),
    .head_valid (head_valid),
    .drop       (drop)
  );

  assign bus.res_data   = head.data;
  assign bus.res_terms  = head.terms;
  assign bus.res_ovf    = head.ovf;
  assign bus.res_valid  = head_valid;
  assign bus.drop_pulse = drop;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Directed bench for mult_product_accumulator with a scoreboard of expected group results.
module tb_mult_product_accumulator;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  result_t exp_q[$];

  mult_product_accumulator_if bus ();

  mult_product_accumulator #(.OUT_DEPTH_P(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [PROD_W-1:0] d, input logic last);
    bus.prod_valid = valid;
    bus.prod_in    = d;
    bus.prod_last  = last;
  endtask

  task automatic expect_res(input logic [ACC_W-1:0] d, input logic [TERM_W-1:0] t, input logic o);
    result_t r;
    r.data  = d;
    r.terms = t;
    r.ovf   = o;
    exp_q.push_back(r);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, ACC_W'(bus.res_valid), '0);
    chk({tag, "_data"}, bus.res_data, '0);
    chk({tag, "_terms"}, ACC_W'(bus.res_terms), '0);
    chk({tag, "_ovf"}, ACC_W'(bus.res_ovf), '0);
    chk({tag, "_drop"}, ACC_W'(bus.drop_pulse), '0);
    chk({tag, "_busy"}, ACC_W'(bus.busy), '0);
  endtask

  // Head must match the oldest outstanding expectation whenever it is valid
  always @(negedge clk) begin
    if (!rst && bus.res_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", ACC_W'(1), ACC_W'(0));
      end else begin
        chk("res_data", bus.res_data, exp_q[0].data);
        chk("res_terms", ACC_W'(bus.res_terms), ACC_W'(exp_q[0].terms));
        chk("res_ovf", ACC_W'(bus.res_ovf), ACC_W'(exp_q[0].ovf));
        if (bus.res_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [143:0]      wide;
    logic [PROD_W-1:0] ones;

    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    bus.res_ready = 1'b0;
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single group 3+5+7
    bus.res_ready = 1'b1;
    drive(1'b1, 128'd3, 1'b0); tick();
    chk("busy_open", ACC_W'(bus.busy), ACC_W'(1));
    chk("no_early_valid", ACC_W'(bus.res_valid), ACC_W'(0));
    drive(1'b1, 128'd5, 1'b0); tick();
    drive(1'b1, 128'd7, 1'b1); expect_res(136'd15, 16'd3, 1'b0); tick();
    chk("latency_valid", ACC_W'(bus.res_valid), ACC_W'(1));
    chk("busy_closed", ACC_W'(bus.busy), ACC_W'(0));
    drive(1'b0, '0, 1'b0); tick();
    tick();

    // One-term groups back to back
    drive(1'b1, 128'h10, 1'b1); expect_res(136'h10, 16'd1, 1'b0); tick();
    drive(1'b1, 128'h20, 1'b1); expect_res(136'h20, 16'd1, 1'b0); tick();
    chk("b2b_drop0", ACC_W'(bus.drop_pulse), ACC_W'(0));
    drive(1'b0, '0, 1'b0); tick();
    chk("b2b_drop1", ACC_W'(bus.drop_pulse), ACC_W'(0));
    tick(); tick();

    // 257 beats of all-ones wrap the 136-bit accumulator
    ones = '1;
    wide = 144'(257) * 144'(ones);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, ones, 1'b0); tick();
    end
    drive(1'b1, ones, 1'b1); expect_res(wide[ACC_W-1:0], 16'd257, 1'b1); tick();
    drive(1'b1, 128'd1, 1'b1); expect_res(136'd1, 16'd1, 1'b0); tick();
    drive(1'b0, '0, 1'b0); tick(); tick(); tick();

    // Backpressure: third result is dropped
    bus.res_ready = 1'b0;
    drive(1'b1, 128'd1, 1'b1); expect_res(136'd1, 16'd1, 1'b0); tick();
    drive(1'b1, 128'd2, 1'b1); expect_res(136'd2, 16'd1, 1'b0); tick();
    drive(1'b1, 128'd3, 1'b1); tick();
    chk("drop_fire", ACC_W'(bus.drop_pulse), ACC_W'(1));
    drive(1'b0, '0, 1'b0); tick();
    chk("drop_once", ACC_W'(bus.drop_pulse), ACC_W'(0));
    chk("head_held", bus.res_data, 136'd1);
    tick();
    bus.res_ready = 1'b1;
    tick(); tick(); tick();
    chk("bp_drained", ACC_W'(bus.res_valid), ACC_W'(0));
    chk("bp_queue_empty", ACC_W'(exp_q.size()), ACC_W'(0));

    // Full buffer with simultaneous push and pop
    bus.res_ready = 1'b0;
    drive(1'b1, 128'd1, 1'b1); expect_res(136'd1, 16'd1, 1'b0); tick();
    drive(1'b1, 128'd2, 1'b1); expect_res(136'd2, 16'd1, 1'b0); tick();
    drive(1'b0, '0, 1'b0); tick();
    bus.res_ready = 1'b1;
    drive(1'b1, 128'd9, 1'b1); expect_res(136'd9, 16'd1, 1'b0); tick();
    chk("pushpop_nodrop", ACC_W'(bus.drop_pulse), ACC_W'(0));
    drive(1'b0, '0, 1'b0); tick(); tick(); tick();
    chk("pushpop_queue_empty", ACC_W'(exp_q.size()), ACC_W'(0));

    // Reset mid-group discards the partial sum silently
    drive(1'b1, 128'd4, 1'b0); tick();
    drive(1'b1, 128'd4, 1'b0); tick();
    chk("busy_before_rst", ACC_W'(bus.busy), ACC_W'(1));
    drive(1'b0, '0, 1'b0);
    rst = 1'b1; tick();
    chk_all_zero("midrst");
    rst = 1'b0; tick();
    chk_all_zero("postrst");
    drive(1'b1, 128'd6, 1'b1); expect_res(136'd6, 16'd1, 1'b0); tick();
    chk("postrst_valid", ACC_W'(bus.res_valid), ACC_W'(1));
    drive(1'b0, '0, 1'b0); tick(); tick();
    chk("final_queue_empty", ACC_W'(exp_q.size()), ACC_W'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mult_product_accumulator.md
Name: mult_product_accumulator

Overview:
- Sits directly downstream of the 64x64 Karatsuba multiplier and consumes its 128-bit product stream.
- Sums products into a guarded accumulator over groups of beats; a group ends on a last-beat marker. Typical use is dot products and multi-term MACs.
- Finished group results go into a small output buffer with a valid/ready handshake.
- The multiplier cannot stall, so this block never backpressures its input. A lost result is flagged instead.

Parameters:
- PROD_W, 128: width of the incoming product.
- GUARD_W, 8: extra accumulator bits above PROD_W.
- ACC_W, PROD_W+GUARD_W (136): accumulator and result width.
- TERM_W, 16: width of the per-group term counter.
- OUT_DEPTH, 2: number of entries in the result buffer (power of two, minimum 2).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- prod_in  in  PROD_W  product from the multiplier, unsigned.
- prod_valid  in  1  prod_in is a real beat this cycle; the valid is delay-matched to the multiplier latency by the issuing side.
- prod_last  in  1  final beat of the current group; qualified by prod_valid.
- res_data  out  ACC_W  group sum at the buffer head.
- res_terms  out  TERM_W  number of beats in that group.
- res_ovf  out  1  the group sum wrapped past ACC_W bits.
- res_valid  out  1  buffer head is valid.
- res_ready  in  1  consumer accepts the buffer head.
- drop_pulse  out  1  one-cycle pulse: a finished result was discarded because the buffer was full.
- busy  out  1  a group is open (at least one beat taken, last beat not yet seen).

Behaviour:
- Reset: one clock with rst=1 puts every output and all state to 0. This covers res_valid, res_data, res_terms, res_ovf, drop_pulse and busy, and also clears the accumulator, term count and buffer pointers.
  - A reset mid-group discards the partial sum silently; no drop_pulse.
  - rst has priority over all other inputs in that cycle.
- Accumulate: a beat with prod_valid=1 and prod_last=0 does the following.
  - acc <= (busy ? acc : 0) + zero_extend(prod_in).
  - terms <= (busy ? terms : 0) + 1, saturating at all-ones.
  - ovf_acc <= (busy ? ovf_acc : 0) | carry-out of the ACC_W addition.
  - busy <= 1.
- Close group: a beat with prod_valid=1 and prod_last=1 does the following.
  - Computes the final sum, terms and ovf with the same rules, including this beat.
  - Pushes them as one entry into the buffer and sets busy <= 0.
  - A single beat with busy=0 and last=1 is a one-term group.
- prod_valid=0: no state change; prod_in and prod_last are ignored.
- Latency: the closing beat at cycle N makes the result visible with res_valid=1 at cycle N+1, provided the buffer was not full.
- Result buffer: synchronous FIFO of OUT_DEPTH entries; the head is presented on res_*.
  - A pop happens when res_valid & res_ready.
  - res_data, res_terms and res_ovf hold steady while res_valid=1 and res_ready=0.
- Full buffer:
  - If a push arrives when the buffer is full and no pop happens that cycle, the new result is dropped.
  - drop_pulse=1 in the next cycle, and buffer contents are unchanged.
  - If a push and a pop happen in the same cycle with the buffer full, the push is accepted (the pop frees the slot) and there is no drop.
- Empty buffer: res_ready while res_valid=0 has no effect.
- The accumulator path never stalls; a beat is accepted every cycle, including back-to-back closing beats.
- Widths: all arithmetic is unsigned modulo 2^ACC_W. Overflow is reported, never saturated.

Decomposition:
- Shared package mult_pkg holds:
  - constants PROD_W=128, ACC_W=136, TERM_W=16;
  - a result record typedef {data[ACC_W], terms[TERM_W], ovf}, also reused by the multiplier wrapper and its consumers.
- One sub-module: mult_result_fifo, a generic synchronous valid/ready FIFO of depth OUT_DEPTH carrying the result record.
- Accumulator and term-count logic stay in the top module.

Test Plan:
- Single group: beats 3, 5, 7 (last on 7), res_ready=1 → one result, data=15, terms=3, ovf=0, res_valid one cycle after the last beat.
- One-term groups back to back: beats 0x10 (last), 0x20 (last) on consecutive cycles → two results, 0x10 then 0x20, each terms=1, no drop.
- Overflow: 257 beats of 2^128-1 (last on the 257th) → data = 257·(2^128-1) mod 2^136, ovf=1, terms=257; the next group has ovf=0.
- Backpressure: res_ready=0, three one-term groups 1, 2, 3 → buffer holds 1 and 2, drop_pulse fires once for 3, head stays 1. Then res_ready=1 → outputs 1 then 2 only.
- Full buffer with push and pop together: buffer full (1, 2), res_ready=1 in the same cycle as closing beat 9 → pops 1 and accepts 9, no drop_pulse, order 1, 2, 9.
- Reset mid-group: beats 4, 4, then rst=1 for one cycle, then 6 (last) → only result is data=6, terms=1; all outputs 0 during and right after reset.
